// File: rtl/dg0045_prog_store.sv
// DG0045 program-memory responder: host loads a 1024x8 image over a
// valid/ready byte stream, then the core fetches opcodes by scanning
// its PC out in two 5-bit halves.
module dg0045_prog_store #(
  parameter int DEPTH    = 1024,
  parameter int RST_HOLD = 8
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  output logic       ld_ready,
  output logic       ld_done,
  output logic [7:0] checksum,
  output logic       core_nreset,
  output logic       PC_MUX,
  input  logic [4:0] PC_HL,
  output logic [7:0] mainROM,
  output logic [9:0] fetch_addr
);

  localparam int AW = 10;
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t        state;
  logic [AW-1:0] wptr;
  logic [LW-1:0] length;
  logic [7:0]    hold_cnt;
  logic [4:0]    lo_q, hi_q;
  logic [7:0]    mem [DEPTH];

  // ld_start outranks a coincident byte, so the byte is only taken without it
  logic accept;
  assign accept = (state == LOAD) && ld_valid && ld_ready && !ld_start;

  // scan runs only once an image is resident and no reload is starting
  logic scan_en;
  assign scan_en = ((state == HOLD) || (state == RUN)) && !ld_start;

  // Load / hold / run sequencing; ld_start from any state restarts the load
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      core_nreset <= 1'b0;
      ld_ready    <= 1'b0;
      ld_done     <= 1'b0;
      checksum    <= 8'h00;
      length      <= '0;
      wptr        <= '0;
      hold_cnt    <= 8'h00;
    end else if (ld_start) begin
      state       <= LOAD;
      core_nreset <= 1'b0;
      ld_ready    <= 1'b1;
      ld_done     <= 1'b0;
      checksum    <= 8'h00;
      length      <= '0;
      wptr        <= '0;
      hold_cnt    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          core_nreset <= 1'b0;
          ld_ready    <= 1'b0;
        end
        LOAD: begin
          if (accept) begin
            wptr     <= wptr + 1'b1;
            length   <= {1'b0, wptr} + 1'b1;
            checksum <= checksum + ld_data;
            // the top address ends the load even without ld_last
            if (ld_last || (wptr == AW'(DEPTH - 1))) begin
              state    <= HOLD;
              ld_ready <= 1'b0;
              hold_cnt <= 8'h00;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == 8'(RST_HOLD - 1)) begin
            state       <= RUN;
            core_nreset <= 1'b1;
            ld_done     <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: core_nreset <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  // Image storage; never reset so a partial image survives a reset
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= ld_data;
  end

  // PC scan: alternate half select and capture the half the core returns
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      PC_MUX <= 1'b0;
      lo_q   <= 5'h00;
      hi_q   <= 5'h00;
    end else if (scan_en) begin
      PC_MUX <= ~PC_MUX;
      if (!PC_MUX) lo_q <= PC_HL;
      else         hi_q <= PC_HL;
    end else begin
      PC_MUX <= 1'b0;
      lo_q   <= 5'h00;
      hi_q   <= 5'h00;
    end
  end

  assign fetch_addr = {hi_q, lo_q};

  // Opcode read; NOP outside RUN or past the loaded image
  always_comb begin
    mainROM = 8'h00;
    if ((state == RUN) && ({1'b0, fetch_addr} < length))
      mainROM = mem[fetch_addr];
  end

endmodule

// File: tb/tb_dg0045_prog_store.sv
// Scoreboard bench for dg0045_prog_store: the driver keeps a byte-level
// model of the loaded image and queues expected release and fetch results;
// monitor processes compare them when the DUT presents them.
module tb_dg0045_prog_store;

  localparam int RST_HOLD = 8;

  logic       clk = 1'b0;
  logic       RESET;
  logic       ld_start, ld_valid, ld_last;
  logic [7:0] ld_data;
  logic       ld_ready, ld_done, core_nreset, PC_MUX;
  logic [7:0] checksum, mainROM;
  logic [4:0] PC_HL;
  logic [9:0] fetch_addr;
  logic [9:0] core_pc;

  dg0045_prog_store #(.DEPTH(1024), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .RESET(RESET), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .ld_done(ld_done), .checksum(checksum), .core_nreset(core_nreset),
    .PC_MUX(PC_MUX), .PC_HL(PC_HL), .mainROM(mainROM),
    .fetch_addr(fetch_addr)
  );

  always #5 clk = ~clk;

  // core side: return the PC half selected by PC_MUX
  assign PC_HL = PC_MUX ? core_pc[9:5] : core_pc[4:0];

  typedef struct { int len; logic [7:0] sum; } rel_t;
  typedef struct { logic [9:0] pc; logic [7:0] rom; } fet_t;
  rel_t rel_q[$];
  fet_t fet_q[$];

  int checks = 0, errors = 0;
  int cyc = 0;

  // reference image
  logic [7:0] ref_mem [1024];
  int         m_len;
  logic [7:0] m_sum;
  bit         m_active, m_run;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // release monitor: counts accepted handshakes and checks each core release
  initial begin
    int  acc_cnt = 0, last_acc = 0;
    bit  prev_nrst = 1'b0;
    rel_t e;
    forever begin
      @(negedge clk);
      if (!RESET || ld_start) acc_cnt = 0;
      else if (ld_valid && ld_ready) begin
        acc_cnt++;
        last_acc = cyc + 1;
      end
      if (core_nreset && !prev_nrst) begin
        if (rel_q.size() == 0) check("unexpected_release", 1, 0);
        else begin
          e = rel_q.pop_front();
          check("accepted_bytes", acc_cnt, e.len);
          check("checksum", checksum, e.sum);
          check("ld_done_at_release", ld_done, 1);
          check("hold_cycles", cyc - last_acc, RST_HOLD);
        end
      end
      prev_nrst = core_nreset;
    end
  end

  // fetch monitor: two edges after a PC is presented the opcode must be valid
  initial begin
    fet_t f;
    forever begin
      wait (fet_q.size() != 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      f = fet_q.pop_front();
      check("fetch_addr", fetch_addr, f.pc);
      check("mainROM", mainROM, f.rom);
    end
  end

  task automatic do_start();
    @(posedge clk); #1 ld_start = 1'b1;
    @(posedge clk); #1 ld_start = 1'b0;
    m_active = 1; m_run = 0; m_len = 0; m_sum = 8'h00;
  endtask

  task automatic send(input logic [7:0] d, input bit last, input int gap);
    repeat (gap) begin
      ld_valid = 1'b0; ld_data = 8'($urandom);
      @(posedge clk); #1;
    end
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    @(posedge clk); #1;
    if (m_active) begin
      ref_mem[m_len] = d;
      m_len++;
      m_sum = m_sum + d;
      if (last || m_len == 1024) begin
        m_active = 0;
        rel_q.push_back('{m_len, m_sum});
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic wait_release();
    for (int i = 0; i < 100 && rel_q.size() != 0; i++) @(posedge clk);
    if (rel_q.size() != 0) begin
      check("release_timeout", 0, 1);
      rel_q.delete();
    end
    m_run = 1;
    #1;
  endtask

  task automatic fetch(input logic [9:0] pc);
    logic [7:0] exp;
    @(posedge clk); #1;
    exp = (m_run && int'(pc) < m_len) ? ref_mem[pc] : 8'h00;
    core_pc = pc;
    fet_q.push_back('{pc, exp});
    for (int i = 0; i < 20 && fet_q.size() != 0; i++) @(posedge clk);
    if (fet_q.size() != 0) begin
      check("fetch_timeout", 0, 1);
      fet_q.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_nreset"}, core_nreset, 0);
    check({tag, "_ld_ready"}, ld_ready, 0);
    check({tag, "_ld_done"}, ld_done, 0);
    check({tag, "_checksum"}, checksum, 0);
    check({tag, "_PC_MUX"}, PC_MUX, 0);
    check({tag, "_fetch_addr"}, fetch_addr, 0);
    check({tag, "_mainROM"}, mainROM, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RESET = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_data = 8'h00; core_pc = 10'h000;
    m_active = 0; m_run = 0; m_len = 0; m_sum = 8'h00;
    #23;
    check_reset_vals("por");
    @(posedge clk); #1 RESET = 1'b1;

    // basic 4-byte image
    do_start();
    check("ld_ready_in_load", ld_ready, 1);
    send(8'h40, 0, 0); send(8'h13, 0, 0); send(8'h80, 0, 0); send(8'h5F, 1, 0);
    check("ld_ready_after_last", ld_ready, 0);
    check("nreset_low_in_hold", core_nreset, 0);
    wait_release();
    fetch(10'h002);
    fetch(10'h005);
    fetch(10'h003);

    // full 1024-byte stream, no ld_last
    do_start();
    for (int i = 0; i < 1024; i++) send(i[7:0], 0, 0);
    check("ld_ready_after_1024", ld_ready, 0);
    ld_valid = 1'b1; ld_data = 8'hAA;
    @(posedge clk); #1 ld_valid = 1'b0;
    wait_release();
    fetch(10'h3FF);
    fetch(10'h155);
    fetch(10'h000);

    // throttled host
    do_start();
    send(8'($urandom), 0, 1); send(8'($urandom), 0, 1); send(8'($urandom), 0, 1);
    send(8'($urandom), 1, 0);
    wait_release();
    for (int a = 0; a < 5; a++) fetch(10'(a));

    // reload from RUN
    do_start();
    check("rerun_core_nreset", core_nreset, 0);
    check("rerun_ld_done", ld_done, 0);
    check("rerun_mainROM", mainROM, 0);
    check("rerun_checksum", checksum, 0);
    check("rerun_ld_ready", ld_ready, 1);
    send(8'($urandom), 0, 0); send(8'($urandom), 1, 0);
    wait_release();
    fetch(10'h001); fetch(10'h002);

    // reset in the middle of a load
    do_start();
    send(8'h11, 0, 0); send(8'h22, 0, 0);
    #2 RESET = 1'b0;
    #1 check_reset_vals("midload");
    m_active = 0; m_run = 0; m_len = 0;
    @(posedge clk); @(posedge clk); #1 RESET = 1'b1;
    do_start();
    send(8'($urandom), 0, 0); send(8'($urandom), 0, 0); send(8'($urandom), 1, 0);
    wait_release();
    for (int a = 0; a < 4; a++) fetch(10'(a));

    // random image with random gaps, random fetches
    do_start();
    n = $urandom_range(5, 20);
    for (int i = 0; i < n; i++) send(8'($urandom), i == n - 1, $urandom_range(0, 2));
    wait_release();
    for (int k = 0; k < 6; k++) fetch(10'($urandom_range(0, n + 3)));

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
